seq_divider: RTL
================

// Module: seq_divider
//
// PURPOSE
//   Iterative restoring shift-subtract unsigned divider: the inverse datapath of
//   the team's shift-add multiplier.
//   Accepts dividend/divisor on a start strobe and retires one quotient bit per
//   cycle, MSB first. Returns quotient, remainder and a divide-by-zero flag.
//   Sits beside the multiplier in the arithmetic unit.
//   The same formal flow checks it: x == q*d + r.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>= 2)
//
// PORTS
//   clk          in   1      rising-edge clock; sole clock domain
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request; sampled only when accepting (IDLE or DONE)
//   dividend     in   WIDTH  unsigned numerator, captured on accepted start
//   divisor      in   WIDTH  unsigned denominator, captured on accepted start
//   busy         out  1      high in RUN state
//   done         out  1      one-cycle pulse; results valid from this cycle
//   quotient     out  WIDTH  result, held until next accepted start
//   remainder    out  WIDTH  result, held until next accepted start
//   div_by_zero  out  1      set with done when divisor==0, held with results
//
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
//     Applies at any time, including mid-RUN. No done pulse follows an aborted op.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE/DONE with start=1: latch the operands; count=0; partial rem=0
//     (width WIDTH+1).
//     divisor!=0 -> RUN.
//     divisor==0 -> DONE next cycle with quotient='1, remainder=dividend,
//       div_by_zero=1 (latency 1).
//   RUN, each cycle:
//     - rem = {rem[WIDTH-1:0], q_shift[WIDTH-1]}; trial = rem - {1'b0, divisor}.
//     - trial >= 0 (MSB clear): rem = trial, shift 1 into q.
//     - Otherwise keep rem and shift 0 into q.
//     - count++.
//     - After WIDTH iterations (count==WIDTH-1) -> DONE.
//   Latency: start sampled at edge N -> done=1 in the cycle after edge N+WIDTH.
//     That is, WIDTH+1 cycles (9 for WIDTH=8).
//   DONE: done=1 for exactly one cycle. quotient/remainder/div_by_zero update on
//     entry to DONE. div_by_zero clears on the next accepted start.
//   Start in the DONE cycle is accepted (back-to-back issue). Start while busy
//     is ignored and operand changes are ignored.
//   Invariants at done, divisor!=0:
//     - remainder < divisor
//     - dividend == quotient*divisor + remainder (in 2*WIDTH bits)
//   Invariants during RUN: partial rem < divisor; count increments by 1 per cycle.
//   Outputs never change outside DONE entry or reset.
//
// STRUCTURE
//   Shared package div_pkg:
//     - state enum {IDLE, RUN, DONE}
//     - DIV_WIDTH_DEFAULT = 8
//     - count width localparam $clog2(WIDTH)+1
//   Sub-module div_step: combinational single iteration.
//     - in: rem, next dividend bit, divisor
//     - out: new rem, quotient bit
//   Top: FSM, operand/quotient shift registers, iteration counter, output regs.
//   Formal: FORMAL block carrying the invariants above as assertions.
//
// TESTING
//   100/7 start@cyc0 -> busy cyc1-8; done@cyc9, q=14, r=2, dbz=0
//   255/1 -> q=255, r=0; 3/200 -> q=0, r=3; 255/255 -> q=1, r=0
//   5/0 -> done 1 cycle after start, q=255, r=5, dbz=1; busy never asserted
//   rst during RUN (cycle 4) -> IDLE next cycle, all outputs 0, no done pulse
//   start in DONE cycle with 200/9 -> next done 9 cycles later, q=22, r=2
//   start pulsed with 50/5 while busy -> ignored; original 100/7 result intact
//   Exhaustive WIDTH=8 sweep or formal proof of q*d+r identity and r<d

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing constants for the sequential shift-subtract divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int DIV_CNT_WIDTH_DEFAULT = $clog2(DIV_WIDTH_DEFAULT) + 1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the arithmetic-unit issuer and the divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  // The held remainder is always below the divisor, so WIDTH bits suffice to
  // store it; the extra bit only exists for the shifted value and the borrow.
  always_comb begin
    rem_shift = {rem_in, next_bit};
    trial     = rem_shift - {1'b0, divisor};
    q_bit     = ~trial[WIDTH];
    rem_out   = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider retiring one quotient bit per cycle, MSB first.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [CNT_W-1:0] count;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_out_r;
  logic             accept;

  assign accept = bus.start && (state != RUN);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem_r),
    .next_bit (q_shift[WIDTH-1]),
    .divisor  (divisor_r),
    .rem_out  (rem_next),
    .q_bit    (q_bit)
  );

  // q_shift starts as the dividend and fills with quotient bits from the LSB,
  // so after WIDTH iterations it holds the full quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q_shift   <= '0;
      divisor_r <= '0;
      rem_r     <= '0;
      count     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
      quot_r    <= '0;
      rem_out_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            q_shift   <= bus.dividend;
            divisor_r <= bus.divisor;
            rem_r     <= '0;
            count     <= '0;
            if (bus.divisor == '0) begin
              state     <= DONE;
              done_r    <= 1'b1;
              quot_r    <= '1;
              rem_out_r <= bus.dividend;
              dbz_r     <= 1'b1;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
              dbz_r  <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          q_shift <= {q_shift[WIDTH-2:0], q_bit};
          rem_r   <= rem_next;
          count   <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            quot_r    <= {q_shift[WIDTH-2:0], q_bit};
            rem_out_r <= rem_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_out_r;
  assign bus.div_by_zero = dbz_r;

`ifdef FORMAL
  logic [WIDTH-1:0] dividend_f;

  always_ff @(posedge clk) begin
    if (!rst && accept) dividend_f <= bus.dividend;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RUN) begin
        assert (rem_r < divisor_r);
        assert (count <= CNT_W'(WIDTH - 1));
      end
      if (done_r && !dbz_r) begin
        assert (rem_out_r < divisor_r);
        assert ((2*WIDTH)'(dividend_f) ==
                (2*WIDTH)'(quot_r) * (2*WIDTH)'(divisor_r) + (2*WIDTH)'(rem_out_r));
      end
    end
  end
`endif

endmodule
